// File: rtl/wb_result_sel_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_sel_if
// Description : Bundle of all non-clock signals of wb_result_sel.
//               master = the environment driving sources/upstream/consumer,
//               slave  = the selector itself.
//   src_data/src_rdy : NSRC execution-unit results and their ready flags
//   in_*             : upstream request (valid, select, rd, wen) / in_ready
//   out_*            : registered result towards the register file
//   stat_clr         : clears stall_cnt and err_sel
//   stall_cnt        : saturating count of cycles waiting on a source
//   err_sel          : sticky out-of-range select flag
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_result_sel_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4
);
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_rdy;
  logic                  in_valid;
  logic [SELW-1:0]       in_sel;
  logic [4:0]            in_rd;
  logic                  in_wen;
  logic                  in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [4:0]            out_rd;
  logic                  out_wen;
  logic                  out_ready;
  logic                  stat_clr;
  logic [15:0]           stall_cnt;
  logic                  err_sel;

  modport master (
    output src_data, src_rdy, in_valid, in_sel, in_rd, in_wen, out_ready, stat_clr,
    input  in_ready, out_valid, out_data, out_rd, out_wen, stall_cnt, err_sel
  );

  modport slave (
    input  src_data, src_rdy, in_valid, in_sel, in_rd, in_wen, out_ready, stat_clr,
    output in_ready, out_valid, out_data, out_rd, out_wen, stall_cnt, err_sel
  );
endinterface
`default_nettype wire

// File: rtl/wb_result_sel.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_sel
// Description : Write-back result selector. Picks one of NSRC source results
//               by in_sel, waits while that source is not ready, and queues
//               the result with its destination tag in a 2-entry buffer
//               (output register + skid register) under valid/ready.
// Ports       : clk, rst_n (async, active-low), bus (wb_result_sel_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_result_sel #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_result_sel_if.slave  bus
);
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  // Occupancy: EMPTY (no entry), ONE (OUT only), FULL (OUT + SKID)
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             out_wen_q, out_wen_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [4:0]       skid_rd_q, skid_rd_d;
  logic             skid_wen_q, skid_wen_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             err_sel_q, err_sel_d;

  logic             sel_in_range;
  logic             sel_ok;
  logic [WIDTH-1:0] sel_data;
  logic             transfer;

  // Source mux. An out-of-range select never waits and yields zero data.
  always_comb begin
    sel_in_range = 1'b0;
    sel_ok       = 1'b1;
    sel_data     = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.in_sel == SELW'(i)) begin
        sel_in_range = 1'b1;
        sel_ok       = bus.src_rdy[i];
        sel_data     = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign transfer = bus.in_valid & in_ready_q & sel_ok;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_wen_d  = skid_wen_q;
    case (state_q)
      EMPTY: begin
        if (transfer) begin
          out_data_d = sel_data;
          out_rd_d   = bus.in_rd;
          out_wen_d  = bus.in_wen;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (transfer && bus.out_ready) begin
          out_data_d = sel_data;
          out_rd_d   = bus.in_rd;
          out_wen_d  = bus.in_wen;
        end else if (transfer) begin
          skid_data_d = sel_data;
          skid_rd_d   = bus.in_rd;
          skid_wen_d  = bus.in_wen;
          state_d     = FULL;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain of SKID into OUT can occur
        if (bus.out_ready) begin
          out_data_d = skid_data_q;
          out_rd_d   = skid_rd_q;
          out_wen_d  = skid_wen_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // Statistics: clear has priority over counting, but an error accepted in
  // the clear cycle still leaves err_sel set.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stat_clr) begin
      stall_cnt_d = 16'd0;
    end else if (bus.in_valid && in_ready_q && !sel_ok && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    err_sel_d = bus.stat_clr ? 1'b0 : err_sel_q;
    if (transfer && !sel_in_range) begin
      err_sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_rd_q    <= 5'd0;
      out_wen_q   <= 1'b0;
      skid_data_q <= '0;
      skid_rd_q   <= 5'd0;
      skid_wen_q  <= 1'b0;
      stall_cnt_q <= 16'd0;
      err_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_wen_q  <= skid_wen_d;
      stall_cnt_q <= stall_cnt_d;
      err_sel_q   <= err_sel_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_wen   = out_wen_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.err_sel   = err_sel_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_result_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_result_sel
// Description : Self-checking bench for wb_result_sel. A queue-based model
//               (capacity 2, FIFO) tracks the NSRC=4 instance; a second
//               NSRC=3 instance exercises out-of-range selects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_result_sel;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_result_sel_if #(.WIDTH(32), .NSRC(4)) bus4 ();
  wb_result_sel_if #(.WIDTH(32), .NSRC(3)) bus3 ();

  wb_result_sel #(.WIDTH(32), .NSRC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  wb_result_sel #(.WIDTH(32), .NSRC(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  // Reference model for dut4
  ent_t        m_q[$];
  int          m_stall = 0;
  bit          m_err = 1'b0;
  bit          m_hold = 1'b0;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vt[4];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stall = 0;
    m_err   = 1'b0;
    m_hold  = 1'b0;
  endtask

  task automatic check4();
    cmp("out_valid", 32'(bus4.out_valid), 32'(m_q.size() > 0));
    cmp("in_ready", 32'(bus4.in_ready), 32'(m_q.size() < 2));
    cmp("stall_cnt", 32'(bus4.stall_cnt), 32'(m_stall));
    cmp("err_sel", 32'(bus4.err_sel), 32'(m_err));
    if (m_q.size() > 0) begin
      cmp("out_data", bus4.out_data, m_q[0].data);
      cmp("out_rd", 32'(bus4.out_rd), 32'(m_q[0].rd));
      cmp("out_wen", 32'(bus4.out_wen), 32'(m_q[0].wen));
    end
  endtask

  // One clock of dut4 plus the model; inputs must already be set.
  task automatic step(input bit chk);
    bit   ok, room, xfer;
    ent_t e;
    int   s;
    s    = int'(bus4.in_sel);
    ok   = (s < 4) ? bus4.src_rdy[s] : 1'b1;
    room = (m_q.size() < 2);
    xfer = bus4.in_valid && room && ok;
    e.data = (s < 4) ? bus4.src_data[32*s +: 32] : 32'd0;
    e.rd   = bus4.in_rd;
    e.wen  = bus4.in_wen;
    @(posedge clk);
    if (m_q.size() > 0 && bus4.out_ready) void'(m_q.pop_front());
    if (xfer) m_q.push_back(e);
    if (bus4.stat_clr) m_stall = 0;
    else if (bus4.in_valid && room && !ok && m_stall < 16'hFFFF) m_stall++;
    if (bus4.stat_clr) m_err = 1'b0;
    if (xfer && s >= 4) m_err = 1'b1;
    m_hold = bus4.in_valid && !xfer;
    #1;
    if (chk) check4();
  endtask

  task automatic tick3();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // source i carries the listed value: 0:11 1:33 2:22 3:44
    vt[0] = '{sel: 2'd0, rd: 5'd1, wen: 1'b1, exp_data: 32'h11};
    vt[1] = '{sel: 2'd3, rd: 5'd2, wen: 1'b0, exp_data: 32'h44};
    vt[2] = '{sel: 2'd1, rd: 5'd3, wen: 1'b1, exp_data: 32'h33};
    vt[3] = '{sel: 2'd2, rd: 5'd31, wen: 1'b1, exp_data: 32'h22};

    bus4.src_data = '0; bus4.src_rdy = '0; bus4.in_valid = 1'b0; bus4.in_sel = '0;
    bus4.in_rd = '0; bus4.in_wen = 1'b0; bus4.out_ready = 1'b0; bus4.stat_clr = 1'b0;
    bus3.src_data = '0; bus3.src_rdy = '0; bus3.in_valid = 1'b0; bus3.in_sel = '0;
    bus3.in_rd = '0; bus3.in_wen = 1'b0; bus3.out_ready = 1'b0; bus3.stat_clr = 1'b0;
    model_reset();

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    cmp("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    cmp("rst_out_data", bus4.out_data, 32'd0);
    cmp("rst_out_rd", 32'(bus4.out_rd), 32'd0);
    cmp("rst_out_wen", 32'(bus4.out_wen), 32'd0);
    cmp("rst_stall", 32'(bus4.stall_cnt), 32'd0);
    cmp("rst_err", 32'(bus4.err_sel), 32'd0);
    cmp("rst3_in_ready", 32'(bus3.in_ready), 32'd1);
    rst_n = 1'b1;

    // ---- back-to-back, table driven ----
    bus4.src_data = {32'h44, 32'h22, 32'h33, 32'h11};
    bus4.src_rdy  = 4'hF;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_sel = vt[i].sel;
      bus4.in_rd  = vt[i].rd;
      bus4.in_wen = vt[i].wen;
      step(1'b1);
      cmp("b2b_data", bus4.out_data, vt[i].exp_data);
      cmp("b2b_valid", 32'(bus4.out_valid), 32'd1);
    end
    bus4.in_valid = 1'b0;
    step(1'b1);

    // ---- source stall ----
    bus4.in_valid = 1'b1; bus4.in_sel = 2'd1; bus4.in_rd = 5'd9; bus4.in_wen = 1'b1;
    bus4.src_rdy = 4'b1101;
    bus4.src_data = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
    for (int i = 0; i < 5; i++) step(1'b1);
    cmp("stall_5", 32'(bus4.stall_cnt), 32'd5);
    cmp("stall_novalid", 32'(bus4.out_valid), 32'd0);
    bus4.src_rdy = 4'hF;
    step(1'b1);
    cmp("stall_release_data", bus4.out_data, 32'hB2);
    bus4.in_valid = 1'b0;
    step(1'b1);

    // ---- backpressure: three requests, two accepted ----
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b1;
    bus4.in_sel = 2'd0; bus4.in_rd = 5'd4; step(1'b1);
    bus4.in_sel = 2'd2; bus4.in_rd = 5'd5; step(1'b1);
    cmp("bp_in_ready_low", 32'(bus4.in_ready), 32'd0);
    bus4.in_sel = 2'd3; bus4.in_rd = 5'd6; step(1'b1);
    cmp("bp_hold_head", bus4.out_data, 32'hA1);
    bus4.out_ready = 1'b1;
    step(1'b1);
    cmp("bp_drain_second", bus4.out_data, 32'hC3);
    cmp("bp_in_ready_back", 32'(bus4.in_ready), 32'd1);
    step(1'b1);
    cmp("bp_third", bus4.out_data, 32'hD4);
    bus4.in_valid = 1'b0;
    step(1'b1);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      if (!m_hold) begin
        bus4.in_valid = ($urandom_range(0, 3) != 0);
        bus4.in_sel   = 2'($urandom_range(0, 3));
        bus4.in_rd    = 5'($urandom);
        bus4.in_wen   = 1'($urandom);
      end
      bus4.src_data  = {$urandom, $urandom, $urandom, $urandom};
      bus4.src_rdy   = 4'($urandom);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      bus4.stat_clr  = ($urandom_range(0, 19) == 0);
      step(1'b1);
    end
    bus4.stat_clr = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    step(1'b1);
    step(1'b1);

    // ---- stall counter saturation ----
    bus4.stat_clr = 1'b1; step(1'b1);
    bus4.stat_clr = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_sel = 2'd1; bus4.src_rdy = 4'b1101;
    for (int i = 0; i < 70000; i++) step(1'b0);
    check4();
    cmp("sat_ffff", 32'(bus4.stall_cnt), 32'h0000FFFF);
    bus4.src_rdy = 4'hF;
    step(1'b1);
    bus4.in_valid = 1'b0;
    step(1'b1);

    // ---- asynchronous reset while FULL ----
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b1;
    bus4.in_sel = 2'd0; bus4.in_rd = 5'd7; step(1'b1);
    bus4.in_sel = 2'd2; bus4.in_rd = 5'd8; step(1'b1);
    cmp("full_before_rst", 32'(bus4.in_ready), 32'd0);
    bus4.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    cmp("arst_out_valid", 32'(bus4.out_valid), 32'd0);
    cmp("arst_in_ready", 32'(bus4.in_ready), 32'd1);
    cmp("arst_out_data", bus4.out_data, 32'd0);
    cmp("arst_stall", 32'(bus4.stall_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);

    // ---- out-of-range select on NSRC=3 instance ----
    bus3.src_data = {32'h3C, 32'h2B, 32'h1A};
    bus3.src_rdy = 3'b111;
    bus3.out_ready = 1'b1;
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd3; bus3.in_rd = 5'd12; bus3.in_wen = 1'b1;
    tick3();
    bus3.in_valid = 1'b0;
    cmp("oor_valid", 32'(bus3.out_valid), 32'd1);
    cmp("oor_data", bus3.out_data, 32'd0);
    cmp("oor_rd", 32'(bus3.out_rd), 32'd12);
    cmp("oor_err", 32'(bus3.err_sel), 32'd1);
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd2;
    tick3();
    cmp("n3_sel2_data", bus3.out_data, 32'h3C);
    cmp("err_sticky", 32'(bus3.err_sel), 32'd1);
    bus3.in_sel = 2'd0; bus3.src_rdy = 3'b110;
    tick3();
    cmp("n3_stall1", 32'(bus3.stall_cnt), 32'd1);
    bus3.in_valid = 1'b0; bus3.src_rdy = 3'b111;
    bus3.stat_clr = 1'b1;
    tick3();
    cmp("clr_err", 32'(bus3.err_sel), 32'd0);
    cmp("clr_stall", 32'(bus3.stall_cnt), 32'd0);
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd3;
    tick3();
    bus3.stat_clr = 1'b0; bus3.in_valid = 1'b0;
    cmp("clr_vs_err", 32'(bus3.err_sel), 32'd1);
    tick3();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
